// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer for the single-ported 64-bit data memory.
// Port 0 (MEM stage) has fixed priority; port 1 (loader/DMA) is forced a
// grant after STARVE_LIMIT consecutive port-0 grants while it waits.
// Optional: define DMEM_BOUNDS_CHECK_EN to add p0_err/p1_err and suppress
// memory strobes for addresses with nonzero bits above the 10-bit word index.
module dmem_port_arbiter #(
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p0_wdata,
    output logic        p0_ack,
    output logic [63:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p1_wdata,
    output logic        p1_ack,
    output logic [63:0] p1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic        p0_err,
    output logic        p1_err,
`endif
    output logic        stall_mem,
    output logic        busy
);

    localparam int unsigned DW    = 64;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              gnt_q, gnt_d;      // 0 = port 0, 1 = port 1
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic [DW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     p0_rdata_q, p0_rdata_d;
    logic [DW-1:0]     p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic              p0_err_q, p0_err_d;
    logic              p1_err_q, p1_err_d;
`endif
    logic              gnt_p1;
    logic [DW-1:0]     rd_val;

    // Next-state, arbitration, field latching and registered output values.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        oob_d       = oob_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;
`endif
        gnt_p1      = 1'b0;
        rd_val      = oob_q ? '0 : mem_rdata;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_p1  = p1_req && (!p0_req || (starve_q == CNT_W'(STARVE_LIMIT)));
                    gnt_d   = gnt_p1;
                    we_d    = gnt_p1 ? p1_we    : p0_we;
                    addr_d  = gnt_p1 ? p1_addr  : p0_addr;
                    wdata_d = gnt_p1 ? p1_wdata : p0_wdata;
`ifdef DMEM_BOUNDS_CHECK_EN
                    oob_d   = |addr_d[DW-1:IDX_W];
`else
                    oob_d   = 1'b0;
`endif
                    wait_d  = CNT_W'(WAIT_STATES);
                    state_d = ACCESS;
                    if (gnt_p1) begin
                        starve_d = '0;
                    end else if (p1_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - CNT_W'(1);
                end else begin
                    if (!we_q) begin
                        if (gnt_q) p1_rdata_d = rd_val;
                        else       p0_rdata_d = rd_val;
                    end
                    p0_ack_d = ~gnt_q;
                    p1_ack_d = gnt_q;
`ifdef DMEM_BOUNDS_CHECK_EN
                    p0_err_d = ~gnt_q & oob_q;
                    p1_err_d = gnt_q & oob_q;
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A port-1 drop-out resets its starvation history.
        if (!p1_req) starve_d = '0;

        mem_read_d  = (state_d == ACCESS) && !we_d && !oob_d;
        mem_write_d = (state_d == ACCESS) &&  we_d && !oob_d;
        mem_addr_d  = (state_d == ACCESS) ? addr_d  : '0;
        mem_wdata_d = (state_d == ACCESS) ? wdata_d : '0;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            starve_q    <= '0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            oob_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            oob_q       <= oob_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef DMEM_BOUNDS_CHECK_EN
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
`endif
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
`endif

    // Hazard-unit stall: port 0 is waiting on an access that has not acked.
    assign stall_mem = p0_req & ~p0_ack_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (WAIT_STATES=1, STARVE_LIMIT=4).
// A transaction granted at edge G shows strobes after G and G+1, ack after G+2.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_mem, busy;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        p0_err, p1_err;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [63:0] mem [1024];

    // Single-ported memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_BOUNDS_CHECK_EN
        .p0_err(p0_err), .p1_err(p1_err),
`endif
        .stall_mem(stall_mem), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_p0_ack", p0_ack, 0);
        check("rst_stall", stall_mem, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        rst_n = 1'b1;
        tick();

        // p0 write 5 <- DEADBEEF
        p0_req = 1; p0_we = 1; p0_addr = 64'd5; p0_wdata = 64'hDEAD_BEEF;
        #1 check("wr_stall_pre", stall_mem, 1);
        tick();
        check("wr_mem_write_c1", mem_write, 1);
        check("wr_mem_addr", mem_addr, 64'd5);
        check("wr_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        check("wr_mem_read", mem_read, 0);
        check("wr_busy", busy, 1);
        check("wr_ack_early", p0_ack, 0);
        tick();
        check("wr_mem_write_c2", mem_write, 1);
        check("wr_stall_mid", stall_mem, 1);
        tick();
        check("wr_mem_write_done", mem_write, 0);
        check("wr_mem_addr_done", mem_addr, 0);
        check("wr_p0_ack", p0_ack, 1);
        check("wr_stall_ack", stall_mem, 0);
        p0_req = 0;
        tick();
        check("wr_ack_one_cycle", p0_ack, 0);
        check("wr_idle_busy", busy, 0);

        // p0 read 5
        p0_req = 1; p0_we = 0; p0_addr = 64'd5; p0_wdata = '0;
        tick();
        check("rd_mem_read", mem_read, 1);
        tick(); tick();
        check("rd_p0_ack", p0_ack, 1);
        check("rd_p0_rdata", p0_rdata, 64'hDEAD_BEEF);
        p0_req = 0;
        tick(); tick();
        check("rd_rdata_hold", p0_rdata, 64'hDEAD_BEEF);

        // p1 write 7: no rdata change on either port
        p1_req = 1; p1_we = 1; p1_addr = 64'd7; p1_wdata = 64'h1111_2222_3333_4444;
        tick();
        check("p1wr_mem_write", mem_write, 1);
        check("p1wr_mem_addr", mem_addr, 64'd7);
        check("p1wr_stall", stall_mem, 0);
        tick(); tick();
        check("p1wr_ack", p1_ack, 1);
        check("p1wr_p0_ack", p0_ack, 0);
        check("p1wr_p1_rdata", p1_rdata, 0);
        check("p1wr_p0_rdata", p0_rdata, 64'hDEAD_BEEF);
        p1_req = 0;
        tick();

        // collision: both read in the same cycle, p0 first
        p0_req = 1; p0_we = 0; p0_addr = 64'd5;
        p1_req = 1; p1_we = 0; p1_addr = 64'd7; p1_wdata = '0;
        tick();
        check("col_first_addr", mem_addr, 64'd5);
        tick(); tick();
        check("col_p0_ack", p0_ack, 1);
        check("col_p1_wait", p1_ack, 0);
        p0_req = 0;
        tick(); tick();
        check("col_second_addr", mem_addr, 64'd7);
        tick(); tick();
        check("col_p1_ack", p1_ack, 1);
        check("col_p1_rdata", p1_rdata, 64'h1111_2222_3333_4444);
        check("col_p0_rdata_kept", p0_rdata, 64'hDEAD_BEEF);
        p1_req = 0;
        tick();

        // starvation: grants p0,p0,p0,p0,p1
        p0_req = 1; p0_we = 0; p0_addr = 64'd5;
        p1_req = 1; p1_we = 0; p1_addr = 64'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("starve_gnt%0d_addr", i), mem_addr, (i == 4) ? 64'd7 : 64'd5);
            check($sformatf("starve_gnt%0d_cnt", i), 64'(dut.starve_q), (i == 4) ? 64'd0 : 64'(i + 1));
            if (i == 4) check("starve_stall_loser", stall_mem, 1);
            tick(); tick();
            check($sformatf("starve_txn%0d_p0_ack", i), p0_ack, (i < 4) ? 1 : 0);
            check($sformatf("starve_txn%0d_p1_ack", i), p1_ack, (i == 4) ? 1 : 0);
            if (i == 4) p1_req = 0;
            tick();
        end
        p0_req = 0; p1_req = 0;
        tick();
        check("starve_cnt_clear", 64'(dut.starve_q), 0);

`ifdef DMEM_BOUNDS_CHECK_EN
        // out-of-range p1 read: no strobe, err with ack, rdata zeroed
        p1_req = 1; p1_we = 0; p1_addr = 64'h400;
        tick();
        check("oob_mem_read_c1", mem_read, 0);
        tick();
        check("oob_mem_read_c2", mem_read, 0);
        tick();
        check("oob_p1_ack", p1_ack, 1);
        check("oob_p1_err", p1_err, 1);
        check("oob_p1_rdata", p1_rdata, 0);
        check("oob_p0_err", p0_err, 0);
        p1_req = 0;
        tick();
        check("oob_err_one_cycle", p1_err, 0);
`else
        // upper address bits pass through; memory indexes word 5
        p1_req = 1; p1_we = 0; p1_addr = 64'h405;
        tick();
        check("alias_mem_read", mem_read, 1);
        check("alias_mem_addr", mem_addr, 64'h405);
        tick(); tick();
        check("alias_p1_ack", p1_ack, 1);
        check("alias_p1_rdata", p1_rdata, 64'hDEAD_BEEF);
        p1_req = 0;
        tick();
`endif

        // reset during ACCESS abandons the read
        p0_req = 1; p0_we = 0; p0_addr = 64'd5;
        tick();
        check("mrst_pre_read", mem_read, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_read_drop", mem_read, 0);
        check("mrst_busy", busy, 0);
        check("mrst_p0_rdata", p0_rdata, 0);
        p0_req = 0;
        tick(); tick();
        check("mrst_no_ack", p0_ack, 0);
        rst_n = 1'b1;
        tick();
        p0_req = 1;
        tick();
        check("mrst_rdata_before", p0_rdata, 0);
        tick();
        check("mrst_rdata_pending", p0_rdata, 0);
        tick();
        check("mrst_p0_ack", p0_ack, 1);
        check("mrst_p0_rdata", p0_rdata, 64'hDEAD_BEEF);
        p0_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
